spike_aer_encoder: RTL and testbench

Downstream stage of the LIF neuron array: captures the parallel spike lines produced by the neurons and serialises them into address-event (AER) words of {neuron address, timestamp}. A round-robin arbiter grants one pending spike per cycle into a small first-word-fall-through FIFO, which drains over a valid/ready handshake. Spikes that arrive faster than they can be serialised are merged and flagged.

---
 rtl/spike_aer_encoder.sv | 203 ++++++++++++++++++++
 tb/tb_spike_aer_encoder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder: captures one-cycle spike pulses from the neuron array,
// arbitrates pending spikes round-robin and queues {address, timestamp}
// events in a small first-word-fall-through FIFO drained by valid/ready.
// Spikes that hit a line whose previous spike is still pending are merged
// (the older stamp is kept) and reported through the sticky ovf flag.
module spike_aer_encoder #(
    parameter int N_LINES    = 8,
    parameter int ADDR_W     = 3,
    parameter int TS_W       = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [N_LINES-1:0]  spike_in,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [ADDR_W-1:0]   ev_addr,
    output logic [TS_W-1:0]     ev_ts,
    output logic [ADDR_W:0]     fifo_count,
    output logic                ovf,
    input  logic                ovf_clr
);

    localparam int                PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_C     = (ADDR_W+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE_C   = (ADDR_W+1)'(1'b1);
    localparam logic [ADDR_W:0]   CNT_ZERO_C  = (ADDR_W+1)'(1'b0);
    localparam logic [ADDR_W-1:0] LAST_LINE_C = ADDR_W'(N_LINES-1);

    // Capture-side state
    logic [TS_W-1:0]    ts_r;
    logic [N_LINES-1:0] pend_r;
    logic [TS_W-1:0]    stamp_r [N_LINES];
    logic [ADDR_W-1:0]  ptr_r;
    logic               ovf_r;

    // FIFO storage, pointers and registered head view
    logic [ADDR_W-1:0]  mem_addr_r [FIFO_DEPTH];
    logic [TS_W-1:0]    mem_ts_r   [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [ADDR_W:0]    count_r;
    logic               ev_valid_r;
    logic [ADDR_W-1:0]  ev_addr_r;
    logic [TS_W-1:0]    ev_ts_r;

    // Combinational helpers
    logic [N_LINES-1:0] new_s;
    logic [N_LINES-1:0] merge_s;
    logic [N_LINES-1:0] grant_s;
    logic               grant_vld_s;
    logic [ADDR_W-1:0]  grant_idx_s;
    logic [ADDR_W-1:0]  cand_s;
    logic               push_s;
    logic               pop_s;
    logic [TS_W-1:0]    push_ts_s;
    logic [ADDR_W:0]    count_next_s;
    logic [PTR_W-1:0]   rd_next_s;
    logic [ADDR_W-1:0]  head_addr_s;
    logic [TS_W-1:0]    head_ts_s;

    assign new_s     = spike_in & {N_LINES{en}};
    assign merge_s   = new_s & pend_r & ~grant_s;
    assign push_s    = grant_vld_s;
    assign pop_s     = ev_valid_r & ev_ready;
    assign push_ts_s = stamp_r[grant_idx_s];

    // Round-robin arbiter: first pending line after ptr, only while the FIFO has room
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = {ADDR_W{1'b0}};
        cand_s      = {ADDR_W{1'b0}};
        grant_s     = {N_LINES{1'b0}};
        if (count_r < DEPTH_C) begin
            for (int k = 1; k <= N_LINES; k++) begin
                if (int'(ptr_r) + k >= N_LINES) begin
                    cand_s = ADDR_W'(int'(ptr_r) + k - N_LINES);
                end else begin
                    cand_s = ADDR_W'(int'(ptr_r) + k);
                end
                if (!grant_vld_s && pend_r[cand_s]) begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = cand_s;
                end else begin
                    grant_vld_s = grant_vld_s;
                end
            end
        end else begin
            grant_vld_s = 1'b0;
        end
        grant_s[grant_idx_s] = grant_vld_s;
    end

    // FIFO next-state: occupancy, read pointer and the head that will be visible next cycle
    always_comb begin
        count_next_s = count_r;
        rd_next_s    = rd_ptr_r;
        head_addr_s  = ev_addr_r;
        head_ts_s    = ev_ts_r;
        if (push_s && !pop_s) begin
            count_next_s = count_r + CNT_ONE_C;
        end else if (!push_s && pop_s) begin
            count_next_s = count_r - CNT_ONE_C;
        end else begin
            count_next_s = count_r;
        end
        if (pop_s) begin
            rd_next_s = rd_ptr_r + PTR_W'(1'b1);
        end else begin
            rd_next_s = rd_ptr_r;
        end
        // The entry being pushed becomes the head when nothing older survives this cycle
        if (count_next_s == CNT_ZERO_C) begin
            head_addr_s = ev_addr_r;
            head_ts_s   = ev_ts_r;
        end else if ((count_r == CNT_ZERO_C) || ((count_r == CNT_ONE_C) && pop_s)) begin
            head_addr_s = grant_idx_s;
            head_ts_s   = push_ts_s;
        end else begin
            head_addr_s = mem_addr_r[rd_next_s];
            head_ts_s   = mem_ts_r[rd_next_s];
        end
    end

    // Free-running capture timestamp, advancing only while capture is enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_r <= {TS_W{1'b0}};
        end else if (en) begin
            ts_r <= ts_r + TS_W'(1'b1);
        end
    end

    // Pending lines, their stamps and the round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r <= {N_LINES{1'b0}};
            ptr_r  <= LAST_LINE_C;
            for (int i = 0; i < N_LINES; i++) begin
                stamp_r[i] <= {TS_W{1'b0}};
            end
        end else begin
            pend_r <= (pend_r & ~grant_s) | new_s;
            if (grant_vld_s) begin
                ptr_r <= grant_idx_s;
            end
            // A merged spike keeps the older stamp; a freshly granted line takes the new one
            for (int i = 0; i < N_LINES; i++) begin
                if (new_s[i] && (!pend_r[i] || grant_s[i])) begin
                    stamp_r[i] <= ts_r;
                end
            end
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_addr_r[wr_ptr_r] <= grant_idx_s;
            mem_ts_r[wr_ptr_r]   <= push_ts_s;
        end
    end

    // FIFO pointers, occupancy and the registered head outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= CNT_ZERO_C;
            ev_valid_r <= 1'b0;
            ev_addr_r  <= {ADDR_W{1'b0}};
            ev_ts_r    <= {TS_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            rd_ptr_r   <= rd_next_s;
            count_r    <= count_next_s;
            ev_valid_r <= (count_next_s != CNT_ZERO_C);
            ev_addr_r  <= head_addr_s;
            ev_ts_r    <= head_ts_s;
        end
    end

    // Sticky merge flag; a new merge wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (|merge_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr) begin
            ovf_r <= 1'b0;
        end
    end

    assign ev_valid   = ev_valid_r;
    assign ev_addr    = ev_addr_r;
    assign ev_ts      = ev_ts_r;
    assign fifo_count = count_r;
    assign ovf        = ovf_r;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Testbench for spike_aer_encoder: directed scenarios plus a randomized run,
// all compared against an event-queue reference model of the encoder.
module tb_spike_aer_encoder;

    localparam int N  = 8;
    localparam int AW = 3;
    localparam int TW = 8;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst, en, ev_ready, ovf_clr;
    logic [N-1:0]  spike_in;
    logic          ev_valid, ovf;
    logic [AW-1:0] ev_addr;
    logic [TW-1:0] ev_ts;
    logic [AW:0]   fifo_count;

    spike_aer_encoder #(.N_LINES(N), .ADDR_W(AW), .TS_W(TW), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_addr(ev_addr), .ev_ts(ev_ts),
        .fifo_count(fifo_count), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Reference model: pending flags + stamps per line, and a queue of events
    logic [AW-1:0] qa [$];
    logic [TW-1:0] qt [$];
    bit            m_pend [N];
    logic [TW-1:0] m_stamp [N];
    int            m_ptr;
    logic [TW-1:0] m_ts;
    bit            m_ovf;

    bit            e_valid;
    logic [AW-1:0] e_addr;
    logic [TW-1:0] e_ts;
    logic [AW:0]   e_count;

    int checks = 0;
    int errors = 0;

    // Apply one cycle of inputs, advance the model, and sample #1 after the edge
    task automatic step(input logic [N-1:0] spk, input bit e, input bit rdy, input bit clr, input bit r);
        int  g;
        bit  merged;
        rst = r; en = e; spike_in = spk; ev_ready = rdy; ovf_clr = clr;
        if (r) begin
            qa.delete(); qt.delete();
            for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_stamp[i] = 8'd0; end
            m_ptr = N - 1; m_ts = 8'd0; m_ovf = 0;
        end else begin
            g = -1;
            if (qa.size() < D) begin
                for (int k = 1; k <= N; k++) begin
                    int idx = (m_ptr + k) % N;
                    if (g < 0 && m_pend[idx]) g = idx;
                end
            end
            if (qa.size() != 0 && rdy) begin
                void'(qa.pop_front()); void'(qt.pop_front());
            end
            if (g >= 0) begin
                qa.push_back(AW'(g)); qt.push_back(m_stamp[g]);
                m_pend[g] = 0; m_ptr = g;
            end
            merged = 0;
            for (int i = 0; i < N; i++) begin
                if (e && spk[i]) begin
                    if (m_pend[i]) merged = 1;
                    else begin m_pend[i] = 1; m_stamp[i] = m_ts; end
                end
            end
            if (merged) m_ovf = 1; else if (clr) m_ovf = 0;
            if (e) m_ts = m_ts + 8'd1;
        end
        @(posedge clk); #1;
        e_valid = (qa.size() != 0);
        e_count = (AW+1)'(qa.size());
        e_addr  = e_valid ? qa[0] : 3'd0;
        e_ts    = e_valid ? qt[0] : 8'd0;
    endtask

    task automatic test_reset();
        step(8'h00, 1, 0, 0, 1);
        step(8'hFF, 1, 0, 0, 1);
        checks++;
        if (ev_valid !== 1'b0 || fifo_count !== 4'd0 || ev_addr !== 3'd0 || ev_ts !== 8'd0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset got v=%b n=%0d a=%0d t=%0d o=%b want all zero", ev_valid, fifo_count, ev_addr, ev_ts, ovf);
        end
    endtask

    task automatic test_single();
        step(8'h00, 1, 0, 0, 1);
        repeat (5) step(8'h00, 1, 0, 0, 0);
        step(8'h04, 1, 0, 0, 0);
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++; $display("FAIL single_latency got v=%b want v=0 one cycle after spike", ev_valid);
        end
        step(8'h00, 1, 0, 0, 0);
        checks++;
        if (ev_valid !== 1'b1 || ev_addr !== 3'd2 || ev_ts !== 8'd5 || ev_ts !== e_ts) begin
            errors++; $display("FAIL single_event got v=%b a=%0d t=%0d want v=1 a=2 t=5", ev_valid, ev_addr, ev_ts);
        end
        step(8'h00, 1, 1, 0, 0);
        checks++;
        if (ev_valid !== 1'b0 || fifo_count !== 4'd0) begin
            errors++; $display("FAIL single_pop got v=%b n=%0d want v=0 n=0", ev_valid, fifo_count);
        end
    endtask

    task automatic test_burst();
        step(8'h00, 1, 1, 0, 1);
        step(8'hFF, 1, 1, 0, 0);
        for (int k = 0; k < N; k++) begin
            step(8'h00, 1, 1, 0, 0);
            checks++;
            if (ev_valid !== 1'b1 || ev_addr !== AW'(k) || ev_ts !== 8'd0 || ovf !== 1'b0 || fifo_count !== e_count) begin
                errors++;
                $display("FAIL burst k=%0d got v=%b a=%0d t=%0d o=%b n=%0d want v=1 a=%0d t=0 o=0 n=%0d", k, ev_valid, ev_addr, ev_ts, ovf, fifo_count, k, e_count);
            end
        end
    endtask

    task automatic test_round_robin();
        step(8'h00, 1, 1, 0, 1);
        step(8'h08, 1, 1, 0, 0);
        step(8'h00, 1, 1, 0, 0);
        checks++;
        if (ev_valid !== 1'b1 || ev_addr !== 3'd3) begin
            errors++; $display("FAIL rr_first got v=%b a=%0d want v=1 a=3", ev_valid, ev_addr);
        end
        step(8'h22, 1, 1, 0, 0);
        step(8'h00, 1, 1, 0, 0);
        checks++;
        if (ev_valid !== 1'b1 || ev_addr !== 3'd5 || ev_addr !== e_addr) begin
            errors++; $display("FAIL rr_second got v=%b a=%0d want v=1 a=5", ev_valid, ev_addr);
        end
        step(8'h00, 1, 1, 0, 0);
        checks++;
        if (ev_valid !== 1'b1 || ev_addr !== 3'd1 || ev_addr !== e_addr) begin
            errors++; $display("FAIL rr_third got v=%b a=%0d want v=1 a=1", ev_valid, ev_addr);
        end
    endtask

    task automatic test_backpressure();
        step(8'h00, 1, 0, 0, 1);
        step(8'hFF, 1, 0, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            step(8'h00, 1, 0, 0, 0);
            checks++;
            if (fifo_count !== e_count || ev_valid !== 1'b1 || ev_addr !== 3'd0) begin
                errors++; $display("FAIL bp_fill k=%0d got n=%0d v=%b a=%0d want n=%0d v=1 a=0", k, fifo_count, ev_valid, ev_addr, e_count);
            end
        end
        checks++;
        if (fifo_count !== 4'd4 || dut.pend_r !== 8'hF0) begin
            errors++; $display("FAIL bp_full got n=%0d pend=%h want n=4 pend=f0", fifo_count, dut.pend_r);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (ev_valid !== 1'b1 || ev_addr !== AW'(k) || fifo_count !== e_count) begin
                errors++; $display("FAIL bp_drain k=%0d got v=%b a=%0d n=%0d want v=1 a=%0d n=%0d", k, ev_valid, ev_addr, fifo_count, k, e_count);
            end
            step(8'h00, 1, 1, 0, 0);
        end
        checks++;
        if (ev_valid !== 1'b0 || fifo_count !== 4'd0) begin
            errors++; $display("FAIL bp_empty got v=%b n=%0d want v=0 n=0", ev_valid, fifo_count);
        end
    endtask

    task automatic test_overflow();
        logic [TW-1:0] t1;
        int            n6;
        logic [TW-1:0] ts6;
        step(8'h00, 1, 0, 0, 1);
        step(8'h0F, 1, 0, 0, 0);
        repeat (4) step(8'h00, 1, 0, 0, 0);
        t1 = m_ts;
        step(8'h40, 1, 0, 0, 0);
        step(8'h00, 1, 0, 0, 0);
        checks++;
        if (ovf !== 1'b0 || fifo_count !== 4'd4) begin
            errors++; $display("FAIL ovf_before got o=%b n=%0d want o=0 n=4", ovf, fifo_count);
        end
        step(8'h40, 1, 0, 0, 0);
        checks++;
        if (ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_set got o=%b want o=1", ovf);
        end
        step(8'h00, 1, 0, 1, 0);
        checks++;
        if (ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_clr got o=%b want o=0", ovf);
        end
        step(8'h40, 1, 0, 1, 0);
        checks++;
        if (ovf !== 1'b1 || ovf !== m_ovf) begin
            errors++; $display("FAIL ovf_set_wins got o=%b want o=1", ovf);
        end
        n6 = 0; ts6 = 8'd0;
        for (int k = 0; k < 8; k++) begin
            step(8'h00, 1, 1, 0, 0);
            checks++;
            if (ev_valid !== e_valid || fifo_count !== e_count || (e_valid && (ev_addr !== e_addr || ev_ts !== e_ts))) begin
                errors++; $display("FAIL ovf_drain k=%0d got v=%b a=%0d t=%0d n=%0d want v=%b a=%0d t=%0d n=%0d", k, ev_valid, ev_addr, ev_ts, fifo_count, e_valid, e_addr, e_ts, e_count);
            end
            if (ev_valid === 1'b1 && ev_addr === 3'd6) begin n6++; ts6 = ev_ts; end
        end
        checks++;
        if (n6 != 1 || ts6 !== t1) begin
            errors++; $display("FAIL ovf_single_event got count=%0d t=%0d want count=1 t=%0d", n6, ts6, t1);
        end
    endtask

    task automatic test_enable_wrap();
        step(8'h00, 1, 1, 0, 1);
        repeat (3) step(8'h01, 0, 1, 0, 0);
        step(8'h00, 0, 1, 0, 0);
        step(8'h00, 0, 1, 0, 0);
        checks++;
        if (ev_valid !== 1'b0 || fifo_count !== 4'd0 || dut.ts_r !== 8'd0) begin
            errors++; $display("FAIL en_off got v=%b n=%0d ts=%0d want v=0 n=0 ts=0", ev_valid, fifo_count, dut.ts_r);
        end
        for (int c = 0; c < 300 && m_ts != 8'hFF; c++) step(8'h00, 1, 1, 0, 0);
        step(8'h00, 1, 1, 0, 0);
        step(8'h01, 1, 1, 0, 0);
        step(8'h00, 1, 1, 0, 0);
        checks++;
        if (ev_valid !== 1'b1 || ev_addr !== 3'd0 || ev_ts !== 8'd0) begin
            errors++; $display("FAIL wrap_stamp got v=%b a=%0d t=%0d want v=1 a=0 t=0", ev_valid, ev_addr, ev_ts);
        end
        step(8'h07, 1, 1, 0, 0);
        repeat (3) step(8'h00, 1, 0, 0, 0);
        checks++;
        if (fifo_count !== 4'd3 || fifo_count !== e_count) begin
            errors++; $display("FAIL rst_pre got n=%0d want n=3", fifo_count);
        end
        step(8'h00, 1, 0, 0, 1);
        checks++;
        if (ev_valid !== 1'b0 || fifo_count !== 4'd0) begin
            errors++; $display("FAIL rst_mid got v=%b n=%0d want v=0 n=0", ev_valid, fifo_count);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] spk;
        step(8'h00, 1, 0, 0, 1);
        for (int c = 0; c < 800; c++) begin
            spk = ($urandom_range(0, 3) == 0) ? N'($urandom) : (N'($urandom) & N'($urandom) & N'($urandom));
            step(spk, $urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
            checks++;
            if (ev_valid !== e_valid || fifo_count !== e_count || ovf !== m_ovf ||
                (e_valid && (ev_addr !== e_addr || ev_ts !== e_ts))) begin
                errors++;
                $display("FAIL random c=%0d got v=%b a=%0d t=%0d n=%0d o=%b want v=%b a=%0d t=%0d n=%0d o=%b",
                         c, ev_valid, ev_addr, ev_ts, fifo_count, ovf, e_valid, e_addr, e_ts, e_count, m_ovf);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; spike_in = 8'h00; ev_ready = 1'b0; ovf_clr = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_round_robin();
        test_backpressure();
        test_overflow();
        test_enable_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
